// File: rtl/vend_pkg.sv
// Shared definitions for the vending core: state encoding, coin values and
// coin helper functions.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SELECT = 3'd1,
    ST_PAY    = 3'd2,
    ST_VEND   = 3'd3,
    ST_CHANGE = 3'd4,
    ST_ADMIN  = 3'd5
  } state_t;

  localparam logic [3:0] COIN_VAL_1  = 4'd1;
  localparam logic [3:0] COIN_VAL_2  = 4'd2;
  localparam logic [3:0] COIN_VAL_5  = 4'd5;
  localparam logic [3:0] COIN_VAL_10 = 4'd10;

  // Coin code 0..3 maps to value 1, 2, 5, 10.
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    return COIN_VAL_1;
      2'd1:    return COIN_VAL_2;
      2'd2:    return COIN_VAL_5;
      default: return COIN_VAL_10;
    endcase
  endfunction

  // Total value of all coin pulses asserted in one cycle (max 18).
  function automatic logic [4:0] coin_sum(input logic [3:0] coins);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      if (coins[i]) s = s + 5'(coin_value(2'(i)));
    end
    return s;
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Coin-by-coin change dispenser: after a load, emits one greedy coin every
// GAP_CYC cycles until the remaining change is zero.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int MONEY_W = 7,
  parameter int GAP_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [MONEY_W-1:0] load_value,
  output logic               coin_out_valid,
  output logic [1:0]         coin_out_code,
  output logic [MONEY_W-1:0] change_left,
  output logic               done
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [GAP_W-1:0] gap_cnt;
  logic [1:0]       pick_code;
  logic             emit;

  // Greedy choice: largest coin not exceeding the remaining change.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pick_code = 2'd0;
    if (change_left >= MONEY_W'(COIN_VAL_10))     pick_code = 2'd3;
    else if (change_left >= MONEY_W'(COIN_VAL_5)) pick_code = 2'd2;
    else if (change_left >= MONEY_W'(COIN_VAL_2)) pick_code = 2'd1;
  end

  assign emit = (change_left != '0) && (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign done = (change_left == '0);

  // Gap counter, remaining change and the registered coin pulse.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt        <= '0;
      change_left    <= '0;
      coin_out_valid <= 1'b0;
      coin_out_code  <= 2'd0;
    end else if (load) begin
      gap_cnt        <= '0;
      change_left    <= load_value;
      coin_out_valid <= 1'b0;
    end else if (emit) begin
      gap_cnt        <= '0;
      change_left    <= change_left - MONEY_W'(coin_value(pick_code));
      coin_out_valid <= 1'b1;
      coin_out_code  <= pick_code;
    end else begin
      coin_out_valid <= 1'b0;
      if (change_left != '0) gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vend_core_n.sv
// N-item vending controller core: selection, payment, vending, coin-by-coin
// change, admin restock, stock table and sales accumulator.
module vend_core_n
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int STOCK_W    = 4,
  parameter int MAX_STOCK  = 15,
  parameter int INIT_STOCK = 5,
  parameter int MONEY_W    = 7,
  parameter int SALE_W     = 10,
  parameter logic [N_ITEMS*MONEY_W-1:0] PRICE_LIST = {7'd5, 7'd4, 7'd3, 7'd2},
  parameter int GAP_CYC    = 4,
  localparam int ID_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               admin_mode,
  input  logic               plus_p,
  input  logic               minus_p,
  input  logic               confirm_p,
  input  logic               return_p,
  input  logic [3:0]         coin_p,
  output logic [2:0]         state,
  output logic [ID_W-1:0]    sel_id,
  output logic [STOCK_W-1:0] sel_stock,
  output logic [MONEY_W-1:0] sel_price,
  output logic [MONEY_W-1:0] paid,
  output logic [MONEY_W-1:0] change_left,
  output logic               coin_out_valid,
  output logic [1:0]         coin_out_code,
  output logic               dispense_p,
  output logic               sold_out,
  output logic               coin_reject_p,
  output logic [SALE_W-1:0]  sales_total
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_ITEMS - 1);
  localparam int SUM_W = MONEY_W + 5;
  localparam int ACC_W = ((SALE_W > MONEY_W) ? SALE_W : MONEY_W) + 1;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    sel_q, sel_d, sel_inc, sel_dec;
  logic [STOCK_W-1:0] stock_q [N_ITEMS];
  logic [STOCK_W-1:0] cur_stock;
  logic [MONEY_W-1:0] cur_price, paid_q, paid_d, paid_new, chg_value;
  logic [SALE_W-1:0]  sales_q, sales_d, sales_sat;
  logic [SUM_W-1:0]   paid_plus;
  logic [ACC_W-1:0]   sales_sum;
  logic               coin_over, stock_dec, stock_inc, reject_d, chg_load, chg_done;
  logic               dispense_q, reject_q;

  assign cur_stock = stock_q[sel_q];
  assign cur_price = PRICE_LIST[int'(sel_q) * MONEY_W +: MONEY_W];
  assign sel_inc   = (sel_q == LAST_ID) ? '0 : sel_q + 1'b1;
  assign sel_dec   = (sel_q == '0) ? LAST_ID : sel_q - 1'b1;

  // A coin batch that would overflow paid is refused as a whole.
  assign paid_plus = SUM_W'(paid_q) + SUM_W'(coin_sum(coin_p));
  assign coin_over = paid_plus > SUM_W'({MONEY_W{1'b1}});
  assign paid_new  = coin_over ? paid_q : paid_plus[MONEY_W-1:0];

  assign sales_sum = ACC_W'(sales_q) + ACC_W'(cur_price);
  assign sales_sat = (sales_sum > ACC_W'({SALE_W{1'b1}})) ? {SALE_W{1'b1}} : sales_sum[SALE_W-1:0];

  // Next-state logic and per-state datapath controls.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    paid_d    = paid_q;
    sales_d   = sales_q;
    stock_dec = 1'b0;
    stock_inc = 1'b0;
    reject_d  = 1'b0;
    chg_load  = 1'b0;
    chg_value = '0;
    case (state_q)
      ST_OFF: if (enable) state_d = ST_SELECT;
      ST_SELECT: begin
        if (!enable)                               state_d = ST_OFF;
        else if (admin_mode)                       state_d = ST_ADMIN;
        else if (confirm_p && cur_stock != '0)     state_d = ST_PAY;
        else if (plus_p && !minus_p)               sel_d   = sel_inc;
        else if (minus_p && !plus_p)               sel_d   = sel_dec;
      end
      ST_PAY: begin
        reject_d = coin_over;
        paid_d   = paid_new;
        // A cancel wins over reaching the price in the same cycle.
        if (return_p || !enable) begin
          chg_load  = 1'b1;
          chg_value = paid_new;
          paid_d    = '0;
          state_d   = ST_CHANGE;
        end else if (paid_new >= cur_price) begin
          state_d = ST_VEND;
        end
      end
      ST_VEND: begin
        stock_dec = 1'b1;
        sales_d   = sales_sat;
        chg_load  = 1'b1;
        chg_value = paid_q - cur_price;
        paid_d    = '0;
        state_d   = (paid_q != cur_price) ? ST_CHANGE : ST_SELECT;
      end
      ST_CHANGE: if (chg_done) state_d = enable ? ST_SELECT : ST_OFF;
      ST_ADMIN: begin
        if (!enable)                        state_d = ST_OFF;
        else if (confirm_p || !admin_mode)  state_d = ST_SELECT;
        else begin
          stock_inc = plus_p && (cur_stock < STOCK_W'(MAX_STOCK));
          if (minus_p) sel_d = sel_inc;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // State, selection, money and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      sel_q      <= '0;
      paid_q     <= '0;
      sales_q    <= '0;
      dispense_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      paid_q     <= paid_d;
      sales_q    <= sales_d;
      dispense_q <= (state_d == ST_VEND);
      reject_q   <= reject_d;
    end
  end

  // Per-item stock counters.
  // NOTE: this array is a handful of flops with a defined power-up stock, so it is reset; a RAM-style table would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else if (stock_dec) begin
      stock_q[sel_q] <= cur_stock - 1'b1;
    end else if (stock_inc) begin
      stock_q[sel_q] <= cur_stock + 1'b1;
    end
  end

  change_dispenser #(
    .MONEY_W (MONEY_W),
    .GAP_CYC (GAP_CYC)
  ) u_change (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (chg_load),
    .load_value     (chg_value),
    .coin_out_valid (coin_out_valid),
    .coin_out_code  (coin_out_code),
    .change_left    (change_left),
    .done           (chg_done)
  );

  assign state         = state_q;
  assign sel_id        = sel_q;
  assign sel_stock     = cur_stock;
  assign sel_price     = cur_price;
  assign paid          = paid_q;
  assign dispense_p    = dispense_q;
  assign coin_reject_p = reject_q;
  assign sold_out      = (cur_stock == '0);
  assign sales_total   = sales_q;

endmodule
